// File: rtl/assoc_buffer_reader.sv
// assoc_buffer_reader
// Walks every key of an associative buffer in ascending order. Each key
// that hits is emitted as a (key, data) pair over a valid/ready handshake.
// Optionally, each emitted entry is cleared in the buffer after the
// consumer accepts it.
//
// Ports
//   clk, rst          : clock, synchronous active-low reset
//   start             : scan request, only honoured while idle
//   clear_after       : clear each emitted entry; captured together with start
//   busy, done        : scan in progress / one-cycle completion pulse
//   buf_ctrl, buf_key : command and key driven to the buffer
//                       (NONE=0, CLR=1, LOAD=2, INCR=3)
//   buf_data_input    : write data to the buffer, tied to zero
//   buf_data_output,
//   buf_valid         : registered lookup result from the buffer
//   out_valid, out_ready,
//   out_key, out_data : emitted pair handshake
//   count             : number of pairs accepted in the current or last scan
module assoc_buffer_reader #(
    parameter int KEY_WIDTH  = 5,
    parameter int DATA_WIDTH = 8,
    parameter int CTRL_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  clear_after,
    output logic                  busy,
    output logic                  done,
    output logic [CTRL_WIDTH-1:0] buf_ctrl,
    output logic [KEY_WIDTH-1:0]  buf_key,
    output logic [DATA_WIDTH-1:0] buf_data_input,
    input  logic [DATA_WIDTH-1:0] buf_data_output,
    input  logic                  buf_valid,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [KEY_WIDTH-1:0]  out_key,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [KEY_WIDTH:0]    count
);

    localparam logic [CTRL_WIDTH-1:0] CMD_NONE = '0;
    localparam logic [CTRL_WIDTH-1:0] CMD_CLR  = CTRL_WIDTH'(1);
    localparam logic [KEY_WIDTH-1:0]  KEY_LAST = '1;

    typedef enum logic [2:0] {
        IDLE, ISSUE, WAIT, EMIT, CLEAR, DONE
    } state_t;

    state_t               state, state_nx;
    logic [KEY_WIDTH-1:0] k;
    logic                 clr_lat;
    logic                 advance;   // current key finished; step to next or finish

    assign buf_data_input = '0;

    always_comb begin
        state_nx  = state;
        busy      = 1'b0;
        done      = 1'b0;
        out_valid = 1'b0;
        buf_ctrl  = CMD_NONE;
        buf_key   = '0;
        advance   = 1'b0;
        case (state)
            IDLE:  if (start) state_nx = ISSUE;
            ISSUE: begin
                busy     = 1'b1;
                buf_key  = k;
                state_nx = WAIT;
            end
            // The buffer registers its lookup, so the result for the key
            // presented during ISSUE is visible here.
            WAIT: begin
                busy    = 1'b1;
                buf_key = k;
                if (buf_valid) state_nx = EMIT;
                else           advance  = 1'b1;
            end
            EMIT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    if (clr_lat) state_nx = CLEAR;
                    else         advance  = 1'b1;
                end
            end
            CLEAR: begin
                busy     = 1'b1;
                buf_key  = k;
                buf_ctrl = CMD_CLR;
                advance  = 1'b1;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        // The last key ends the scan; k never wraps.
        if (advance) state_nx = (k == KEY_LAST) ? DONE : ISSUE;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            k        <= '0;
            count    <= '0;
            clr_lat  <= 1'b0;
            out_key  <= '0;
            out_data <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start) begin
                k       <= '0;
                count   <= '0;
                clr_lat <= clear_after;
            end
            if (advance && k != KEY_LAST) k <= k + 1'b1;
            if (state == WAIT && buf_valid) begin
                out_key  <= k;
                out_data <= buf_data_output;
            end
            if (state == EMIT && out_ready) count <= count + 1'b1;
        end
    end

endmodule

// File: tb/tb_assoc_buffer_reader.sv
// Bench for assoc_buffer_reader. Contains a registered associative buffer
// model and a reference model that predicts, from the buffer contents, the
// pairs a scan should emit, the total busy time and the final count.
module tb_assoc_buffer_reader;
    localparam int KW = 5, DW = 8, CW = 2, NK = 32;

    logic clk = 0, rst = 0, start = 0, clear_after = 0, out_ready = 0;
    logic busy, done, out_valid, buf_valid;
    logic [CW-1:0] buf_ctrl;
    logic [KW-1:0] buf_key, out_key;
    logic [DW-1:0] buf_data_input, buf_data_output, out_data;
    logic [KW:0]   count;

    assoc_buffer_reader #(.KEY_WIDTH(KW), .DATA_WIDTH(DW), .CTRL_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .clear_after(clear_after),
        .busy(busy), .done(done), .buf_ctrl(buf_ctrl), .buf_key(buf_key),
        .buf_data_input(buf_data_input), .buf_data_output(buf_data_output),
        .buf_valid(buf_valid), .out_valid(out_valid), .out_ready(out_ready),
        .out_key(out_key), .out_data(out_data), .count(count));

    always #5 clk = ~clk;

    // Buffer model: one-cycle registered lookup; CLR invalidates the entry.
    bit          bv[NK];
    bit [DW-1:0] bd[NK];
    bit          ld_en = 0, ld_v = 0;
    bit [KW-1:0] ld_key = 0;
    bit [DW-1:0] ld_d = 0;
    always @(posedge clk) begin
        if (ld_en) begin
            bv[ld_key] <= ld_v;
            bd[ld_key] <= ld_d;
        end
        if (buf_ctrl == 2'd1) bv[buf_key] <= 1'b0;
        buf_valid       <= bv[buf_key];
        buf_data_output <= bd[buf_key];
    end

    // Reference contents and per-pair consumer wait (cycles out_ready held low).
    bit          rv[NK];
    bit [DW-1:0] rd[NK];
    int          wt[NK];
    int vec = 0, bad = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(int key, bit v, bit [DW-1:0] d);
        @(negedge clk);
        ld_en = 1; ld_key = key[KW-1:0]; ld_v = v; ld_d = d;
        @(negedge clk);
        ld_en = 0;
        rv[key] = v; rd[key] = d;
    endtask

    task automatic wipe();
        for (int i = 0; i < NK; i++) load(i, 1'b0, 8'h00);
    endtask

    // Runs one scan; restart_at >= 0 pulses start at that cycle of the scan.
    task automatic run_scan(bit clr, int restart_at);
        int ek[$];
        int ed[$];
        int exp_busy, busy_n, idx, vcnt, pend_key;
        bit pend_clr, seen_done;
        exp_busy = 2 * NK;
        for (int i = 0; i < NK; i++)
            if (rv[i]) begin
                ek.push_back(i);
                ed.push_back(int'(rd[i]));
                exp_busy += wt[ek.size()-1] + 1 + (clr ? 1 : 0);
            end
        busy_n = 0; idx = 0; vcnt = 0; pend_clr = 0; pend_key = 0; seen_done = 0;
        @(negedge clk);
        start = 1; clear_after = clr; out_ready = 0;
        @(negedge clk);
        start = 0; clear_after = ~clr;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (busy) busy_n++;
            chk("bdi_zero", buf_data_input, 0);
            if (pend_clr) begin
                chk("clr_ctrl", buf_ctrl, 1);
                chk("clr_key", buf_key, pend_key);
            end else
                chk("no_clr", buf_ctrl == 2'd1, 0);
            pend_clr = 0;
            if (out_valid) begin
                if (idx < ek.size()) begin
                    chk("out_key", out_key, ek[idx]);
                    chk("out_data", out_data, ed[idx]);
                    out_ready = (vcnt >= wt[idx]);
                    if (out_ready) begin
                        if (clr) begin pend_clr = 1; pend_key = ek[idx]; end
                        idx++; vcnt = 0;
                    end else vcnt++;
                end else begin
                    chk("extra_pair", 1, 0);
                    out_ready = 1;
                end
            end else out_ready = 1'($urandom_range(0, 1));
            if (done) begin seen_done = 1; break; end
            start = (cyc == restart_at);
            @(negedge clk);
        end
        start = 0;
        chk("done_seen", seen_done, 1);
        chk("busy_cycles", busy_n, exp_busy);
        chk("pairs", idx, ek.size());
        chk("count", count, ek.size());
        @(negedge clk);
        chk("done_pulse", done, 0);
        chk("idle_busy", busy, 0);
        chk("count_hold", count, ek.size());
        if (clr) foreach (ek[i]) rv[ek[i]] = 0;
    endtask

    initial begin
        int n;
        foreach (wt[i]) wt[i] = 0;
        // Reset state
        rst = 0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);      chk("rst_done", done, 0);
        chk("rst_oval", out_valid, 0); chk("rst_okey", out_key, 0);
        chk("rst_odata", out_data, 0); chk("rst_ctrl", buf_ctrl, 0);
        chk("rst_bkey", buf_key, 0);   chk("rst_count", count, 0);
        chk("rst_bdi", buf_data_input, 0);
        rst = 1;
        wipe();
        // Empty buffer
        run_scan(0, -1);
        // Single hit, no clear
        load(7, 1, 8'hA5);
        run_scan(0, -1);
        // Backpressure on key 3
        load(7, 0, 0); load(3, 1, 8'h3C);
        wt[0] = 10;
        run_scan(0, -1);
        wt[0] = 0;
        // Clear-after on keys 0 and 31, then rescan finds nothing
        load(3, 0, 0); load(0, 1, 8'h11); load(31, 1, 8'hEE);
        wt[0] = 2;
        run_scan(1, -1);
        wt[0] = 0;
        run_scan(0, -1);
        // start during busy is ignored
        load(5, 1, 8'h55); load(20, 1, 8'h20);
        run_scan(0, 20);
        // Reset while emitting key 12
        wipe();
        load(12, 1, 8'hC0); load(25, 1, 8'h25);
        @(negedge clk);
        start = 1; out_ready = 0;
        @(negedge clk);
        start = 0;
        n = 0;
        while (!out_valid && n < 200) begin @(negedge clk); n++; end
        chk("mid_reach_emit", out_valid, 1);
        chk("mid_key", out_key, 12);
        rst = 0;
        @(negedge clk);
        rst = 1;
        chk("mid_oval", out_valid, 0); chk("mid_busy", busy, 0);
        chk("mid_count", count, 0);    chk("mid_ctrl", buf_ctrl, 0);
        chk("mid_done", done, 0);      chk("mid_okey", out_key, 0);
        repeat (3) begin
            @(negedge clk);
            chk("mid_quiet", {done, busy, buf_ctrl}, 0);
        end
        run_scan(0, -1);
        // Randomized contents, consumer stalls and clear mode
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < NK; i++)
                load(i, ($urandom_range(0, 3) == 0), 8'($urandom));
            foreach (wt[i]) wt[i] = $urandom_range(0, 3);
            run_scan(1'($urandom_range(0, 1)), (r == 2) ? 7 : -1);
            run_scan(0, -1);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end
endmodule
